// File: rtl/jesd204b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jesd204b_pkg
// Description : Shared types and constants for the JESD204B RX link controller
// Revision    : 1.0 - initial release
// ============================================================================
package jesd204b_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_SLIDE_CHK  = 3'd1,
        ST_SLIDE_WAIT = 3'd2,
        ST_CGS        = 3'd3,
        ST_SYNC_REL   = 3'd4,
        ST_ILAS       = 3'd5,
        ST_DATA       = 3'd6
    } state_t;

    localparam logic [7:0] c_K28_5 = 8'hBC;
    localparam logic [7:0] c_K28_0 = 8'h1C;
    localparam logic [7:0] c_K28_3 = 8'h7C;
    localparam int         c_NOCT  = 4;

    function automatic int lmfc_period(input int f, input int k);
        return (f * k) / c_NOCT;
    endfunction

    function automatic logic is_ctrl_char(input logic [7:0] oct, input logic k);
        return k && ((oct == c_K28_0) || (oct == c_K28_3) || (oct == c_K28_5));
    endfunction

endpackage
`default_nettype wire

// File: rtl/jesd204b_lmfc_counter.sv
`default_nettype none
// ============================================================================
// Module      : jesd204b_lmfc_counter
// Description : LMFC counter, phase-aligned by the first SYSREF rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module jesd204b_lmfc_counter #(
    parameter int PERIOD = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sysref,
    output logic o_tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sysref_d;
    logic          r_seen;
    logic          r_tick;
    logic [CW-1:0] w_cnt_inc;
    logic          w_align;

    assign w_cnt_inc = (r_cnt == CW'(PERIOD - 1)) ? '0 : r_cnt + 1'b1;
    assign w_align   = i_sysref && !r_sysref_d && !r_seen;

    // The tick is registered from the next count so it is low during reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_sysref_d <= 1'b0;
            r_seen     <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_sysref_d <= i_sysref;
            if (w_align) begin
                r_cnt  <= '0;
                r_seen <= 1'b1;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_tick <= (w_cnt_inc == '0);
            end
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/jesd204b_rx_link_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jesd204b_rx_link_fsm
// Description : JESD204B RX lane link FSM: comma slide, CGS, ILAS, DATA gating
// Revision    : 1.0 - initial release
// ============================================================================
module jesd204b_rx_link_fsm
    import jesd204b_pkg::*;
#(
    parameter int USERDATA_WIDTH = 32,
    parameter int SLIDE_WAIT     = 32,
    parameter int MAX_SLIDES     = 20,
    parameter int CGS_COUNT      = 4,
    parameter int F              = 1,
    parameter int K              = 32,
    parameter int ILAS_MF        = 4,
    parameter int ERR_THRESH     = 8
) (
    input  logic                      i_usrclk,
    input  logic                      i_rst_n,
    input  logic                      i_gt_ready,
    input  logic [USERDATA_WIDTH-1:0] i_rx_data,
    input  logic [3:0]                i_rx_charisk,
    input  logic [3:0]                i_rx_disperr,
    input  logic [3:0]                i_rx_notintable,
    input  logic                      i_sysref,
    output logic                      o_rxslide,
    output logic                      o_nsync,
    output logic                      o_lmfc_tick,
    output logic                      o_link_up,
    output logic [USERDATA_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic                      o_align_err,
    output logic [2:0]                o_state
);

    localparam int LMFC_PERIOD = lmfc_period(F, K);
    localparam int SL_W = $clog2(MAX_SLIDES + 1);
    localparam int WT_W = $clog2(SLIDE_WAIT + 1);
    localparam int RN_W = $clog2(CGS_COUNT + 1);
    localparam int MF_W = $clog2(ILAS_MF + 1);
    localparam int ER_W = $clog2(ERR_THRESH + 1);
    localparam logic [3:0] c_CGS_MISS    = 4'd8;
    localparam logic [2:0] c_DATA_KBURST = 3'd4;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [SL_W-1:0]           r_slide_cnt;
    logic [WT_W-1:0]           r_wait_cnt;
    logic [RN_W-1:0]           r_run_cnt;
    logic [3:0]                r_miss_cnt;
    logic [MF_W-1:0]           r_mf_cnt;
    logic [ER_W-1:0]           r_err_cnt;
    logic [2:0]                r_kb_cnt;
    logic                      r_rxslide;
    logic                      r_align_err;
    logic                      r_nsync;
    logic [USERDATA_WIDTH-1:0] r_data;
    logic                      r_data_valid;

    logic w_oct0_k, w_oct3_a, w_all_k, w_err, w_lmfc_tick;
    logic w_slide, w_release, w_sweep_end, w_stay;

    jesd204b_lmfc_counter #(
        .PERIOD (LMFC_PERIOD)
    ) u_lmfc (
        .i_clk    (i_usrclk),
        .i_rst_n  (i_rst_n),
        .i_sysref (i_sysref),
        .o_tick   (w_lmfc_tick)
    );

    assign w_oct0_k    = i_rx_charisk[0] && (i_rx_data[7:0] == c_K28_5);
    assign w_oct3_a    = i_rx_charisk[3] && (i_rx_data[31:24] == c_K28_3);
    assign w_err       = |{i_rx_disperr, i_rx_notintable};
    assign w_sweep_end = (r_slide_cnt + 1'b1) == SL_W'(MAX_SLIDES);
    assign w_stay      = (w_state_nxt == r_state);

    always_comb begin
        w_all_k = 1'b1;
        for (int i = 0; i < c_NOCT; i++) begin
            if (!(i_rx_charisk[i] && (i_rx_data[8*i +: 8] == c_K28_5))) w_all_k = 1'b0;
        end
    end

    always_ff @(posedge i_usrclk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RESET;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slide     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_RESET:      if (i_gt_ready) w_state_nxt = ST_SLIDE_CHK;
            ST_SLIDE_CHK: begin
                if (w_oct0_k) begin
                    w_state_nxt = ST_CGS;
                end else begin
                    w_slide     = 1'b1;
                    w_state_nxt = ST_SLIDE_WAIT;
                end
            end
            ST_SLIDE_WAIT: if (r_wait_cnt == WT_W'(SLIDE_WAIT - 1)) w_state_nxt = ST_SLIDE_CHK;
            ST_CGS: begin
                if (w_all_k && !w_err && ((r_run_cnt + 1'b1) == RN_W'(CGS_COUNT)))
                    w_state_nxt = ST_SYNC_REL;
                else if (!w_oct0_k && ((r_miss_cnt + 1'b1) == c_CGS_MISS))
                    w_state_nxt = ST_SLIDE_CHK;
            end
            ST_SYNC_REL: begin
                if (w_lmfc_tick) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_ILAS;
                end
            end
            ST_ILAS: begin
                if (w_err)
                    w_state_nxt = ST_CGS;
                else if (w_oct3_a && ((r_mf_cnt + 1'b1) == MF_W'(ILAS_MF)))
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_err && ((r_err_cnt + 1'b1) == ER_W'(ERR_THRESH)))
                    w_state_nxt = ST_CGS;
                else if (w_all_k && ((r_kb_cnt + 1'b1) == c_DATA_KBURST))
                    w_state_nxt = ST_CGS;
            end
            default:       w_state_nxt = ST_RESET;
        endcase
        // Losing the transceiver overrides everything, including a pending slide
        if (!i_gt_ready) begin
            w_state_nxt = ST_RESET;
            w_slide     = 1'b0;
            w_release   = 1'b0;
        end
    end

    always_ff @(posedge i_usrclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slide_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_run_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_mf_cnt     <= '0;
            r_err_cnt    <= '0;
            r_kb_cnt     <= '0;
            r_rxslide    <= 1'b0;
            r_align_err  <= 1'b0;
            r_nsync      <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_rxslide   <= w_slide;
            r_align_err <= w_slide && w_sweep_end;

            if (w_state_nxt == ST_SLIDE_CHK || w_state_nxt == ST_SLIDE_WAIT) begin
                if (w_slide) r_slide_cnt <= w_sweep_end ? '0 : r_slide_cnt + 1'b1;
            end else begin
                r_slide_cnt <= '0;
            end

            r_wait_cnt <= (r_state == ST_SLIDE_WAIT && w_stay) ? r_wait_cnt + 1'b1 : '0;
            r_run_cnt  <= (r_state == ST_CGS && w_stay && w_all_k && !w_err) ? r_run_cnt + 1'b1 : '0;
            r_miss_cnt <= (r_state == ST_CGS && w_stay && !w_oct0_k) ? r_miss_cnt + 1'b1 : '0;
            r_kb_cnt   <= (r_state == ST_DATA && w_stay && w_all_k) ? r_kb_cnt + 1'b1 : '0;

            if (r_state == ST_ILAS && w_stay) begin
                if (w_oct3_a) r_mf_cnt <= r_mf_cnt + 1'b1;
            end else begin
                r_mf_cnt <= '0;
            end

            if (r_state == ST_DATA && w_stay) begin
                if (w_err) r_err_cnt <= r_err_cnt + 1'b1;
            end else begin
                r_err_cnt <= '0;
            end

            if (w_release)
                r_nsync <= 1'b1;
            else if (w_state_nxt == ST_CGS || w_state_nxt == ST_RESET)
                r_nsync <= 1'b0;

            if (w_state_nxt == ST_RESET)
                r_data <= '0;
            else if (r_state == ST_DATA)
                r_data <= i_rx_data;
            r_data_valid <= (r_state == ST_DATA) && (w_state_nxt == ST_DATA) && !w_err;
        end
    end

    assign o_rxslide    = r_rxslide;
    assign o_align_err  = r_align_err;
    assign o_nsync      = r_nsync;
    assign o_lmfc_tick  = w_lmfc_tick;
    assign o_link_up    = (r_state == ST_DATA);
    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_rx_link_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_jesd204b_rx_link_fsm
// Description : Directed, table-driven bench for the JESD204B RX link FSM
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd204b_rx_link_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gt_ready = 1'b0;
    logic        sysref = 1'b0;
    logic [31:0] rx_data = '0;
    logic [3:0]  rx_k = '0, rx_de = '0, rx_nit = '0;
    logic        rxslide, nsync, tick, link_up, dvalid, align_err;
    logic [31:0] odata;
    logic [2:0]  state;

    jesd204b_rx_link_fsm dut (
        .i_usrclk        (clk),
        .i_rst_n         (rst_n),
        .i_gt_ready      (gt_ready),
        .i_rx_data       (rx_data),
        .i_rx_charisk    (rx_k),
        .i_rx_disperr    (rx_de),
        .i_rx_notintable (rx_nit),
        .i_sysref        (sysref),
        .o_rxslide       (rxslide),
        .o_nsync         (nsync),
        .o_lmfc_tick     (tick),
        .o_link_up       (link_up),
        .o_data          (odata),
        .o_data_valid    (dvalid),
        .o_align_err     (align_err),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  k;
        logic [3:0]  de;
        logic [2:0]  st;
        logic        nsync;
        logic        link;
        logic        valid;
        logic [31:0] odata;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;
    bit   gen_comma = 1'b0;
    int   rot = 2;
    int   pend = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle; models the GT applying each slide as a one-octet rotation 10 cycles later
    task automatic step();
        @(posedge clk);
        #1;
        if (rxslide && pend < 0) pend = cyc + 10;
        if (pend == cyc) begin
            rot  = (rot + 3) % 4;
            pend = -1;
        end
        if (gen_comma) begin
            rx_data = 32'hBC << (8 * rot);
            rx_k    = 4'b0001 << rot;
            rx_de   = '0;
            rx_nit  = '0;
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de, input logic [3:0] nit);
        rx_data = d;
        rx_k    = k;
        rx_de   = de;
        rx_nit  = nit;
    endtask

    task automatic addv(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de, input logic [2:0] st,
                        input logic ns, input logic lk, input logic vl, input logic [31:0] od);
        vec_t v;
        v.data = d; v.k = k; v.de = de; v.st = st;
        v.nsync = ns; v.link = lk; v.valid = vl; v.odata = od;
        tv.push_back(v);
    endtask

    task automatic add_ilas();
        for (int m = 0; m < 4; m++) begin
            addv(32'h0302011C, 4'b0001, 4'b0000, 3'd5, 1'b1, 1'b0, 1'b0, 32'h0);
            addv(32'h7C020100, 4'b1000, 4'b0000, (m == 3) ? 3'd6 : 3'd5, 1'b1, m == 3, 1'b0, 32'h0);
        end
    endtask

    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(tv[i].data, tv[i].k, tv[i].de, 4'b0000);
            step();
            chk("tbl_state", {29'b0, state}, {29'b0, tv[i].st});
            chk("tbl_nsync", {31'b0, nsync}, {31'b0, tv[i].nsync});
            chk("tbl_link_up", {31'b0, link_up}, {31'b0, tv[i].link});
            chk("tbl_valid", {31'b0, dvalid}, {31'b0, tv[i].valid});
            if (tv[i].valid) chk("tbl_data", odata, tv[i].odata);
        end
    endtask

    int slide_cyc[2];
    int nsl, nerr, bad, n_a, pt;
    bit seen_align;

    initial begin
        // Table A: ILAS, payload, then 8 disparity errors
        add_ilas();
        addv(32'hDEADBEEF, 4'b0000, 4'b0000, 3'd6, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
        addv(32'h12345678, 4'b0000, 4'b0000, 3'd6, 1'b1, 1'b1, 1'b1, 32'h12345678);
        for (int e = 0; e < 8; e++)
            addv(32'hA5A50000 + e, 4'b0000, 4'b0001, (e == 7) ? 3'd3 : 3'd6,
                 e != 7, e != 7, 1'b0, 32'h0);
        n_a = tv.size();
        // Table B: ILAS, payload, then a 4-word K28.5 burst
        add_ilas();
        addv(32'h01020304, 4'b0000, 4'b0000, 3'd6, 1'b1, 1'b1, 1'b1, 32'h01020304);
        for (int b = 0; b < 4; b++)
            addv(32'hBCBCBCBC, 4'b1111, 4'b0000, (b == 3) ? 3'd3 : 3'd6,
                 b != 3, b != 3, b != 3, 32'hBCBCBCBC);

        // Reset values
        repeat (3) step();
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_nsync", {31'b0, nsync}, 32'd0);
        chk("rst_rxslide", {31'b0, rxslide}, 32'd0);
        chk("rst_link_up", {31'b0, link_up}, 32'd0);
        chk("rst_valid", {31'b0, dvalid}, 32'd0);
        chk("rst_align_err", {31'b0, align_err}, 32'd0);
        chk("rst_tick", {31'b0, tick}, 32'd0);
        chk("rst_data", odata, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_state", {29'b0, state}, 32'd0);

        // Comma alignment from a 2-octet offset
        gen_comma = 1'b1;
        rot = 2;
        gt_ready = 1'b1;
        nsl = 0;
        seen_align = 1'b0;
        for (int n = 0; n < 300 && state != 3'd3; n++) begin
            step();
            if (rxslide) begin
                if (nsl < 2) slide_cyc[nsl] = cyc;
                nsl++;
            end
            if (align_err) seen_align = 1'b1;
        end
        chk("align_state", {29'b0, state}, 32'd3);
        chk("align_slides", nsl, 32'd2);
        chk("align_gap", slide_cyc[1] - slide_cyc[0], 32'd33);
        chk("align_no_err", {31'b0, seen_align}, 32'd0);

        // SYSREF alignment of the LMFC, second edge ignored
        while (cyc < 1000) step();
        sysref = 1'b1;
        repeat (20) begin
            step();
            sysref = (cyc == 1003);
            chk("lmfc_tick", {31'b0, tick}, (cyc == 1001 || cyc == 1009 || cyc == 1017) ? 32'd1 : 32'd0);
        end
        chk("cgs_hold", {29'b0, state}, 32'd3);

        // CGS completes at 1025; SYNC~ released only on the tick at 1033
        step();
        step();
        gen_comma = 1'b0;
        drive(32'hBCBCBCBC, 4'b1111, 4'b0000, 4'b0000);
        repeat (14) begin
            step();
            chk("rel_nsync", {31'b0, nsync}, (cyc >= 1034) ? 32'd1 : 32'd0);
            chk("rel_state", {29'b0, state}, (cyc <= 1025) ? 32'd3 : (cyc <= 1033) ? 32'd4 : 32'd5);
        end

        run_table(0, n_a - 1);

        // An error on the word that would complete CGS blocks completion
        for (int i = 0; i < 8; i++) begin
            drive(32'hBCBCBCBC, 4'b1111, 4'b0000, (i == 3) ? 4'b0010 : 4'b0000);
            step();
            chk("cgs_err_block", {29'b0, state}, (i == 7) ? 32'd4 : 32'd3);
        end
        pt = 0;
        for (int n = 0; n < 20 && state != 3'd5; n++) begin
            pt = tick;
            step();
        end
        chk("ilas_entry", {29'b0, state}, 32'd5);
        chk("ilas_nsync", {31'b0, nsync}, 32'd1);
        chk("ilas_after_tick", pt, 32'd1);

        run_table(n_a, tv.size() - 1);

        // No comma at all: fall back from CGS and sweep slides
        drive(32'h11223344, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("cgs_loss", {29'b0, state}, (i == 7) ? 32'd1 : 32'd3);
        end
        nsl = 0;
        nerr = 0;
        bad = 0;
        for (int n = 0; n < 2000 && nsl < 40; n++) begin
            step();
            if (rxslide) nsl++;
            if (align_err) begin
                nerr++;
                if (!rxslide || (nsl % 20) != 0) bad++;
            end
        end
        chk("sweep_slides", nsl, 32'd40);
        chk("sweep_align_err", nerr, 32'd2);
        chk("sweep_align_pos", bad, 32'd0);

        // Losing the GT mid-wait returns to RESET; LMFC phase survives
        repeat (5) step();
        chk("wait_state", {29'b0, state}, 32'd2);
        gt_ready = 1'b0;
        step();
        chk("gt_drop_state", {29'b0, state}, 32'd0);
        chk("gt_drop_nsync", {31'b0, nsync}, 32'd0);
        repeat (16) begin
            step();
            chk("gt_drop_rxslide", {31'b0, rxslide}, 32'd0);
            chk("gt_drop_tick", {31'b0, tick}, (((cyc - 1001) % 8) == 0) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jesd204b_rx_link_fsm.md
Name: jesd204b_rx_link_fsm

Overview:
Receive-side JESD204B link controller for one GT lane, running in the user clock domain.
- Drives the GT RXSLIDE input until K28.5 lands in octet 0 of the 32-bit user word.
- Runs code-group sync (CGS), releases o_nsync on an LMFC boundary, and tracks ILAS.
- Gates payload to user logic once in DATA; falls back to CGS on errors.
- Sits between the GT wrapper and the AXI-S conversion logic inside the RX controller.

Parameters:
USERDATA_WIDTH, 32, user word width; only 32 is supported (4 octets, NOCT = 4).
SLIDE_WAIT, 32, idle cycles after each rxslide pulse before the next comma check.
MAX_SLIDES, 20, slides per sweep before o_align_err pulses and the count wraps.
CGS_COUNT, 4, consecutive all-K28.5 words required to complete CGS.
F, 1, octets per frame.
K, 32, frames per multiframe. F*K must be divisible by 4; LMFC_PERIOD = F*K/4 words (8 at defaults).
ILAS_MF, 4, multiframes in ILAS.
ERR_THRESH, 8, errored words in DATA that force a return to CGS.

Ports:
i_usrclk  in  1  user/data clock
i_rst_n  in  1  asynchronous active-low reset
i_gt_ready  in  1  GT reset-done, already synchronous to i_usrclk
i_rx_data  in  32  decoded octets; octet 0 = [7:0]
i_rx_charisk  in  4  per-octet K flag
i_rx_disperr  in  4  per-octet disparity error
i_rx_notintable  in  4  per-octet not-in-table error
i_sysref  in  1  SYSREF, synchronous to i_usrclk
o_rxslide  out  1  one-cycle slide pulse to GT
o_nsync  out  1  SYNC~, low = sync request
o_lmfc_tick  out  1  one-cycle pulse at LMFC count 0
o_link_up  out  1  high in DATA
o_data  out  32  registered payload
o_data_valid  out  1  payload qualifier
o_align_err  out  1  one-cycle pulse on slide-sweep wrap
o_state  out  3  current state encoding

Behaviour:
- Reset (async assert, synchronous release): all outputs 0, including o_nsync (sync requested). State is RESET, the LMFC counter is 0 and the SYSREF-seen flag is clear.
- Definitions:
  - K28.5 = octet 0xBC with K set.
  - /R/ = 0x1C with K set.
  - /A/ = 0x7C with K set.
  - A word is errored if any disperr or notintable bit is set.
- LMFC counter:
  - Counts 0..LMFC_PERIOD-1 and wraps.
  - o_lmfc_tick is high in every cycle where the count is 0.
  - The first i_sysref rising edge after reset loads 0 in the next cycle, overriding the increment. Later edges are ignored.
  - Before the first edge the counter free-runs.
- States and encodings:
  - RESET (0): wait for i_gt_ready = 1, then go to SLIDE_CHK.
  - SLIDE_CHK (1):
    - If octet 0 is K28.5, go to CGS.
    - Otherwise pulse o_rxslide for 1 cycle, increment the slide count and go to SLIDE_WAIT.
    - When the slide count reaches MAX_SLIDES, pulse o_align_err and clear the count.
  - SLIDE_WAIT (2): count SLIDE_WAIT cycles, then go to SLIDE_CHK. No slide pulse is issued in this state.
  - CGS (3):
    - A word with all four octets K28.5 and no error increments the run count; any other word clears it.
    - When the run count reaches CGS_COUNT, go to SYNC_REL.
    - If octet 0 is not K28.5 for 8 consecutive words, return to SLIDE_CHK.
  - SYNC_REL (4): wait for the next o_lmfc_tick. In that same cycle o_nsync goes to 1 (registered, visible the next cycle), then go to ILAS.
  - ILAS (5):
    - /R/ in octet 0 is accepted as the multiframe start.
    - Each /A/ in octet 3 increments the multiframe count.
    - After ILAS_MF /A/ have been counted, go to DATA in the next cycle.
    - An errored word returns to CGS.
  - DATA (6):
    - o_link_up = 1.
    - o_data / o_data_valid are a registered copy of i_rx_data with 1-cycle latency. Valid is 0 for errored words.
    - Errored words increment the error count. Reaching ERR_THRESH goes to CGS.
    - 4 consecutive all-K28.5 words also go to CGS.
- Any transition into CGS: o_nsync = 0, o_link_up = 0 and o_data_valid = 0 in the next cycle; all run, error and multiframe counters are cleared.
- i_gt_ready falling in any state returns to RESET in the next cycle with the reset values applied. The LMFC counter and SYSREF-seen flag are kept.
- Simultaneous events:
  - A SYSREF edge together with a counter wrap gives count 0 (only one tick is emitted).
  - An error on the same word that completes CGS blocks completion, because the error clears the run count.

Decomposition:
- jesd204b_pkg holds:
  - the state enum (3-bit);
  - the K28_5/K28_0/K28_3 octet constants;
  - the NOCT constant;
  - an lmfc_period function of F and K.
- One sub-module, jesd204b_lmfc_counter: SYSREF edge detect, first-edge capture, counter and tick output.
- The FSM stays in the top module.

Test Plan:
1. Reset, then i_gt_ready = 1 with K28.5 initially in octet 2 (2-octet misalignment). The bench models each slide as a 1-octet rotation with 10-cycle latency. Expect rxslide pulses spaced 33 cycles apart, then CGS, with o_state = 3.
2. SYSREF pulse at cycle 1000. Expect o_lmfc_tick at cycles 1001, 1009, 1017 (period 8). A second pulse at cycle 1003 does not disturb the phase.
3. Bench sends 4 all-K28.5 words. Expect o_nsync to rise exactly one cycle after the next LMFC tick and never between ticks.
4. /R/ … /A/ repeated ×4 multiframes, then data 0xDEADBEEF. Expect o_link_up = 1 and o_data = 0xDEADBEEF with o_data_valid one cycle after input.
5. In DATA, inject 8 words with disperr = 4'b0001. Expect a return to CGS, o_nsync = 0 and o_link_up = 0. A 4-word K28.5 burst also forces CGS.
6. Never present K28.5. Expect o_align_err every 20 slides. Then deassert i_gt_ready mid-SLIDE_WAIT: expect RESET next cycle and o_rxslide held at 0.
